uart_tx_arbiter: RTL

Shares the single UART transmitter of the sender board between two byte sources: keyboard ASCII bytes and switch-entered bytes from the btnU path. Each source has its own small FIFO, so a byte that arrives while the transmitter is busy is queued instead of overwritten. The block grants FIFOs round-robin and sequences the transmitter with a one-cycle start pulse and a tx_busy handshake. It sits between the keyboard decode / button logic and the uart instance, and replaces the direct send_data/en_send register.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 117 +++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - byte-source, UART handshake and status signals of uart_tx_arbiter
interface uart_tx_arbiter_if;
    logic       kb_valid;
    logic [7:0] kb_data;
    logic       sw_valid;
    logic [7:0] sw_data;
    logic       tx_busy;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       kb_full;
    logic       sw_full;
    logic       kb_drop;
    logic       sw_drop;
    logic       idle;

    modport master (
        output kb_valid, kb_data, sw_valid, sw_data, tx_busy,
        input  tx_start, tx_data, kb_full, sw_full, kb_drop, sw_drop, idle
    );

    modport slave (
        input  kb_valid, kb_data, sw_valid, sw_data, tx_busy,
        output tx_start, tx_data, kb_full, sw_full, kb_drop, sw_drop, idle
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - two per-source byte FIFOs granted round-robin onto one UART transmitter
module uart_tx_arbiter #(
    parameter int DEPTH     = 4,
    parameter int BUSY_WAIT = 8
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(BUSY_WAIT) + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    logic [7:0]    kb_mem_q [DEPTH];
    logic [7:0]    sw_mem_q [DEPTH];
    logic [PW-1:0] kb_wr_q, kb_rd_q, sw_wr_q, sw_rd_q;
    logic          kb_drop_q, sw_drop_q;

    state_t        state_q;
    logic          tx_start_q;
    logic [7:0]    tx_data_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_sw_q;

    logic kb_empty, sw_empty, kb_full, sw_full;
    logic kb_push, sw_push, kb_pop, sw_pop;
    logic grant_en, grant_kb;
    logic [7:0] kb_head, sw_head;

    // Extra pointer bit distinguishes full from empty when the low bits match.
    assign kb_empty = (kb_wr_q == kb_rd_q);
    assign sw_empty = (sw_wr_q == sw_rd_q);
    assign kb_full  = (kb_wr_q[AW] != kb_rd_q[AW]) && (kb_wr_q[AW-1:0] == kb_rd_q[AW-1:0]);
    assign sw_full  = (sw_wr_q[AW] != sw_rd_q[AW]) && (sw_wr_q[AW-1:0] == sw_rd_q[AW-1:0]);

    assign kb_head = kb_mem_q[kb_rd_q[AW-1:0]];
    assign sw_head = sw_mem_q[sw_rd_q[AW-1:0]];

    assign grant_en = (state_q == IDLE) && !bus.tx_busy && (!kb_empty || !sw_empty);
    assign grant_kb = !kb_empty && (sw_empty || last_sw_q);

    assign kb_pop  = grant_en && grant_kb;
    assign sw_pop  = grant_en && !grant_kb;
    // Fullness is judged before this cycle's pop, so a push into a full FIFO is lost.
    assign kb_push = bus.kb_valid && !kb_full;
    assign sw_push = bus.sw_valid && !sw_full;

    assign cnt_d = cnt_q + CW'(1);

    always_ff @(posedge clk) begin
        if (kb_push) kb_mem_q[kb_wr_q[AW-1:0]] <= bus.kb_data;
        if (sw_push) sw_mem_q[sw_wr_q[AW-1:0]] <= bus.sw_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            kb_wr_q   <= '0;
            kb_rd_q   <= '0;
            sw_wr_q   <= '0;
            sw_rd_q   <= '0;
            kb_drop_q <= 1'b0;
            sw_drop_q <= 1'b0;
        end else begin
            if (kb_push) kb_wr_q <= kb_wr_q + PW'(1);
            if (sw_push) sw_wr_q <= sw_wr_q + PW'(1);
            if (kb_pop)  kb_rd_q <= kb_rd_q + PW'(1);
            if (sw_pop)  sw_rd_q <= sw_rd_q + PW'(1);
            if (bus.kb_valid && kb_full) kb_drop_q <= 1'b1;
            if (bus.sw_valid && sw_full) sw_drop_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            tx_start_q <= 1'b0;
            tx_data_q  <= 8'h00;
            cnt_q      <= '0;
            last_sw_q  <= 1'b1;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (grant_en) begin
                        tx_data_q  <= grant_kb ? kb_head : sw_head;
                        last_sw_q  <= !grant_kb;
                        cnt_q      <= '0;
                        tx_start_q <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: state_q <= WAIT_BUSY;
                WAIT_BUSY: begin
                    // A transmitter that never raises busy must not stall the arbiter.
                    if (bus.tx_busy) begin
                        state_q <= WAIT_DONE;
                    end else begin
                        cnt_q <= cnt_d;
                        if (cnt_d == CW'(BUSY_WAIT - 1)) state_q <= IDLE;
                    end
                end
                WAIT_DONE: if (!bus.tx_busy) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;
    assign bus.kb_full  = kb_full;
    assign bus.sw_full  = sw_full;
    assign bus.kb_drop  = kb_drop_q;
    assign bus.sw_drop  = sw_drop_q;
    assign bus.idle     = (state_q == IDLE) && kb_empty && sw_empty;
endmodule
